countdown_arbiter: RTL

//  Shares one down-counting timer between N_REQ requesters. Arbitration is round-robin.
//  The granted requester's count is loaded, decremented once per clock to 0, then the

---
 rtl/countdown_arbiter_if.sv | 59 +++++
 rtl/countdown_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/countdown_arbiter_if.sv
// rtl/countdown_arbiter_if.sv - request/grant bundle between requesters and the shared countdown timer
//
// Purpose:
//   Carries the requester-side signals into countdown_arbiter and its status back out.
//   The master side belongs to the requesters and the slave side to the arbiter.
//
// Signals:
//   req        master->slave  N_REQ          per-requester request level
//   req_count  master->slave  N_REQ*WIDTH    packed load values, requester i at [i*WIDTH +: WIDTH]
//   pause      master->slave  1              only when CDA_PAUSE_EN is defined; holds the count
//   grant      slave->master  N_REQ          one-hot grant, zero when idle
//   busy       slave->master  1              countdown in progress
//   count      slave->master  WIDTH          current timer value
//   done       slave->master  1              one-cycle pulse, countdown reached zero
//   abort      slave->master  1              one-cycle pulse, owner dropped req early
//   owner      slave->master  $clog2(N_REQ)  index of current or last grant
//
// Optional feature macro: CDA_PAUSE_EN
interface countdown_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    localparam int OW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_count;
`ifdef CDA_PAUSE_EN
    logic                   pause;
`endif
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic [WIDTH-1:0]       count;
    logic                   done;
    logic                   abort;
    logic [OW-1:0]          owner;

`ifdef CDA_PAUSE_EN
    modport master (
        output req, req_count, pause,
        input  grant, busy, count, done, abort, owner
    );

    modport slave (
        input  req, req_count, pause,
        output grant, busy, count, done, abort, owner
    );
`else
    modport master (
        output req, req_count,
        input  grant, busy, count, done, abort, owner
    );

    modport slave (
        input  req, req_count,
        output grant, busy, count, done, abort, owner
    );
`endif

endinterface

// File: rtl/countdown_arbiter.sv
// rtl/countdown_arbiter.sv - round-robin arbiter sharing one down-counting timer
//
// Purpose:
//   N_REQ requesters compete for a single down-counter. The winner's load value is
//   captured at grant, the counter decrements once per clock to zero, then done pulses
//   and the grant is released. Dropping req while granted ends the countdown with abort.
//   Arbitration is round-robin: the pointer moves to owner+1 after every grant ends.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high reset
//   bus    slave modport of countdown_arbiter_if (req, req_count, [pause] in;
//          grant, busy, count, done, abort, owner out)
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   WIDTH  counter width in bits
//
// Optional feature macro: CDA_PAUSE_EN
//   When defined, bus.pause=1 during a countdown holds the count. The abort and done
//   checks still run while paused, so a paused count of zero still completes.
module countdown_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    countdown_arbiter_if.slave   bus
);

    localparam int OW = $clog2(N_REQ);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [OW-1:0]    ptr_q,   ptr_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             done_q,  done_d;
    logic             abort_q, abort_d;

    logic [OW-1:0]    sel;
    logic             sel_vld;
    logic [OW-1:0]    owner_next;
    logic             pause_act;

`ifdef CDA_PAUSE_EN
    assign pause_act = bus.pause;
`else
    assign pause_act = 1'b0;
`endif

    // Round-robin pick: first requester found scanning ptr, ptr+1, ... with wrap.
    // Indices are folded back explicitly so non-power-of-two N_REQ never wanders
    // past the last requester.
    always_comb begin
        int j;
        sel     = '0;
        sel_vld = 1'b0;
        j       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!sel_vld && bus.req[OW'(j)]) begin
                sel_vld = 1'b1;
                sel     = OW'(j);
            end
        end
    end

    // Pointer value after the current owner releases: owner+1 mod N_REQ.
    always_comb begin
        if (owner_q == OW'(N_REQ - 1)) begin
            owner_next = '0;
        end else begin
            owner_next = owner_q + OW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        count_d = count_q;
        grant_d = grant_q;
        done_d  = 1'b0;
        abort_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d      = COUNT;
                    owner_d      = sel;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    // Load value is captured only here; later req_count changes are ignored.
                    count_d      = bus.req_count[sel*WIDTH +: WIDTH];
                end
            end

            COUNT: begin
                // Early release wins over completion so a dropped request never reports done.
                if (!bus.req[owner_q]) begin
                    abort_d = 1'b1;
                    grant_d = '0;
                    ptr_d   = owner_next;
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    done_d  = 1'b1;
                    grant_d = '0;
                    ptr_d   = owner_next;
                    state_d = IDLE;
                end else if (!pause_act) begin
                    count_d = count_q - WIDTH'(1);
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            count_q <= '0;
            grant_q <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            count_q <= count_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state_q == COUNT);
    assign bus.count = count_q;
    assign bus.done  = done_q;
    assign bus.abort = abort_q;
    assign bus.owner = owner_q;

endmodule
